// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, fetches one word per request, hands it to decode.
// Latency: a word acked in cycle N is presented to decode in cycle N+1; peak rate is one word per 2 cycles.
// Backpressure: while decode holds instr_ready low the word is held stable and no new fetch is issued.
//
// Ports:
//   clk, rst                     - clock and async active-high reset
//   pc / pc_seq                  - current PC to the external incrementer, PC+1 back from it
//   imem_req/addr/ack/rdata      - instruction memory request and response
//   instr_valid/ready/instr/pc   - valid/ready handshake towards decode
//   redirect, redirect_pc        - branch/jump target; discards in-flight work
//   halt, halted                 - HLT seen on an accepted handshake; core stopped
//   fetch_count                  - number of accepted instructions (wraps)
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc,
    input  logic [15:0] pc_seq,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state;

    // Request is derived from registered state only; reset masks it so the
    // bus is quiet for the whole time rst is high.
    assign imem_req  = (state == S_FETCH) && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            case (state)
                S_FETCH: begin
                    if (redirect) begin
                        // A same-cycle ack is dropped: the word belongs to the
                        // abandoned path.
                        pc <= redirect_pc;
                    end else if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        pc          <= pc_seq;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (instr_ready) begin
                        fetch_count <= fetch_count + 16'd1;
                        instr_valid <= 1'b0;
                        if (halt) begin
                            // Halt beats a simultaneous redirect; pc stays put.
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else begin
                            if (redirect) begin
                                pc <= redirect_pc;
                            end
                            state <= S_FETCH;
                        end
                    end else if (redirect) begin
                        pc          <= redirect_pc;
                        instr_valid <= 1'b0;
                        state       <= S_FETCH;
                    end
                end

                S_HALTED: begin
                    // Sticky until reset; redirect has no effect here.
                    halted      <= 1'b1;
                    instr_valid <= 1'b0;
                end

                default: begin
                    state       <= S_FETCH;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
